// File: rtl/imem_loader.sv
// imem_loader
//   Writer side of the instruction memory. Takes a byte stream over a
//   valid/ready handshake and writes the words it carries to consecutive
//   instruction-memory addresses. A trailing checksum byte is then verified.
//   The core is held in reset for the whole load, so it only starts fetching
//   after a load that completed cleanly.
//
//   Stream: LEN_HI, LEN_LO (word count N, big-endian),
//           N x (DATA_HI, DATA_LO), CHECK (sum mod 256 of all previous bytes).
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   start          one-cycle pulse, begins a load from IDLE, DONE or ERROR
//   in_valid       in_data holds a byte
//   in_data        stream byte
//   in_ready       loader takes a byte this cycle
//   mem_wen        one-cycle instruction-memory write strobe
//   mem_addr       write address (BASE_ADDR + word index, wraps)
//   mem_wdata      write data
//   core_rst       core reset, high while loading or after a failed load
//   done           load finished with a good checksum
//   err            load failed (over-length or bad checksum)
//   words_written  number of write strobes in the current load
module imem_loader #(
  parameter int unsigned      ISIZE     = 16,
  parameter int unsigned      DSIZE     = 16,
  parameter logic [ISIZE-1:0] BASE_ADDR = '0,
  parameter int unsigned      MAX_WORDS = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             mem_wen,
  output logic [ISIZE-1:0] mem_addr,
  output logic [DSIZE-1:0] mem_wdata,
  output logic             core_rst,
  output logic             done,
  output logic             err,
  output logic [15:0]      words_written
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      len_q, len_d;
  logic [7:0]       hi_q, hi_d;
  logic [7:0]       sum_q, sum_d;
  logic [15:0]      words_written_q, words_written_d;
  logic             mem_wen_q, mem_wen_d;
  logic [ISIZE-1:0] mem_addr_q, mem_addr_d;
  logic [DSIZE-1:0] mem_wdata_q, mem_wdata_d;
  logic             in_ready_q, in_ready_d;
  logic             core_rst_q, core_rst_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             accept;
  logic [15:0]      len_full;
  logic             loading_next;

  // in_ready is registered from the next state, so it always matches the
  // state the loader is in when the byte is sampled.
  assign accept   = in_valid & in_ready_q;
  assign len_full = {len_q[15:8], in_data};

  always_comb begin
    state_d         = state_q;
    len_d           = len_q;
    hi_d            = hi_q;
    sum_d           = sum_q;
    words_written_d = words_written_q;
    mem_wen_d       = 1'b0;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d         = S_LEN_HI;
          words_written_d = 16'd0;
          sum_d           = 8'd0;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d   = {in_data, 8'd0};
          sum_d   = sum_q + in_data;
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d = len_full;
          sum_d = sum_q + in_data;
          if (32'(len_full) > MAX_WORDS) begin
            state_d = S_ERROR;
          end else if (len_full == 16'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        if (accept) begin
          hi_d    = in_data;
          sum_d   = sum_q + in_data;
          state_d = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (accept) begin
          mem_wen_d       = 1'b1;
          mem_wdata_d     = DSIZE'({hi_q, in_data});
          // words_written_q is the index of the word being completed.
          mem_addr_d      = BASE_ADDR + ISIZE'(words_written_q);
          words_written_d = words_written_q + 16'd1;
          sum_d           = sum_q + in_data;
          // N <= MAX_WORDS, so the +1 cannot overflow 16 bits.
          if (words_written_q + 16'd1 == len_q) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA_HI;
          end
        end
      end
      S_CHECK: begin
        if (accept) begin
          state_d = (in_data == sum_q) ? S_DONE : S_ERROR;
        end
      end
      default: state_d = S_IDLE;
    endcase

    loading_next = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                   (state_d == S_DATA_HI) || (state_d == S_DATA_LO) ||
                   (state_d == S_CHECK);
    in_ready_d = loading_next;
    core_rst_d = loading_next || (state_d == S_ERROR);
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERROR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      len_q           <= 16'd0;
      hi_q            <= 8'd0;
      sum_q           <= 8'd0;
      words_written_q <= 16'd0;
      mem_wen_q       <= 1'b0;
      mem_addr_q      <= BASE_ADDR;
      mem_wdata_q     <= '0;
      in_ready_q      <= 1'b0;
      core_rst_q      <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      len_q           <= len_d;
      hi_q            <= hi_d;
      sum_q           <= sum_d;
      words_written_q <= words_written_d;
      mem_wen_q       <= mem_wen_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      in_ready_q      <= in_ready_d;
      core_rst_q      <= core_rst_d;
      done_q          <= done_d;
      err_q           <= err_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign mem_wen       = mem_wen_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign core_rst      = core_rst_q;
  assign done          = done_q;
  assign err           = err_q;
  assign words_written = words_written_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  localparam int MAX_W = 256;
  localparam logic [15:0] BASE = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        mem_wen;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        core_rst;
  logic        done;
  logic        err;
  logic [15:0] words_written;

  always #5 clk = ~clk;

  imem_loader #(.ISIZE(16), .DSIZE(16), .BASE_ADDR(BASE), .MAX_WORDS(MAX_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .core_rst(core_rst), .done(done), .err(err),
    .words_written(words_written)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model (stream-position based) -------------
  bit          m_busy, m_done, m_err;
  int          m_pos, m_n, m_words;
  logic [7:0]  m_hi, m_sum;
  logic [31:0] exp_q[$];   // {addr, data} of writes the DUT owes
  logic [31:0] wr_log[$];  // {addr, data} of writes the DUT made
  bit          chk_en = 1'b0;

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_err = 0; m_pos = 0; m_n = 0; m_words = 0;
    m_hi = 0; m_sum = 0; exp_q.delete();
  endtask

  task automatic model_start();
    if (!m_busy) begin
      m_busy = 1; m_done = 0; m_err = 0; m_pos = 0; m_n = 0; m_words = 0; m_sum = 0;
    end
  endtask

  task automatic model_accept(input logic [7:0] b);
    if (m_pos == 0) begin
      m_n = int'(b) * 256; m_sum = m_sum + b;
    end else if (m_pos == 1) begin
      m_n = m_n + int'(b); m_sum = m_sum + b;
      if (m_n > MAX_W) begin m_busy = 0; m_err = 1; end
    end else if (m_pos < 2 * m_n + 2) begin
      m_sum = m_sum + b;
      if ((m_pos % 2) == 0) m_hi = b;
      else begin
        exp_q.push_back({16'(int'(BASE) + (m_pos - 3) / 2), m_hi, b});
        m_words++;
      end
    end else begin
      m_busy = 0;
      if (b == m_sum) m_done = 1; else m_err = 1;
    end
    m_pos++;
  endtask

  // ---------------- per-cycle compare against the model ------------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", {31'd0, in_ready}, {31'd0, m_busy});
      check("core_rst", {31'd0, core_rst}, {31'd0, m_busy | m_err});
      check("done", {31'd0, done}, {31'd0, m_done});
      check("err", {31'd0, err}, {31'd0, m_err});
      check("words_written", {16'd0, words_written}, 32'(m_words));
      if (mem_wen) begin
        wr_log.push_back({mem_addr, mem_wdata});
        if (exp_q.size() == 0) check("unexpected_wen", {31'd0, mem_wen}, 32'd0);
        else check("write", {mem_addr, mem_wdata}, exp_q.pop_front());
      end else if (exp_q.size() != 0) begin
        check("missing_wen", {31'd0, mem_wen}, 32'd1);
        exp_q.delete();
      end
    end
  end

  // ---------------- stimulus helpers -------------------------------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1; start = 0; in_valid = 0;
    @(posedge clk);
    model_reset();
    chk_en = 1'b1;
    #1 rst = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1;
    @(posedge clk);
    model_start();
    #1 start = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    if (gap) begin
      @(negedge clk); in_valid = 0;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1; in_data = b;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); @(negedge clk); n++;
    end
    if (!in_ready) begin
      check("ready_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 0;
    end else begin
      @(posedge clk);
      model_accept(b);
      #1 in_valid = 0;
    end
  endtask

  task automatic send_stream(input logic [7:0] s[$], input bit gap);
    foreach (s[i]) send_byte(s[i], gap);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // ---------------- directed tests --------------------------------------
  initial begin
    do_reset();
    settle(1);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'h0);
    check("rst_mem_wdata", {16'd0, mem_wdata}, 32'h0);
    check("rst_core_rst", {31'd0, core_rst}, 32'd0);

    // nominal
    wr_log.delete();
    pulse_start();
    send_stream('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0}, 1'b0);
    settle(2);
    check("nom_nwr", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() == 2) begin
      check("nom_wr0", wr_log[0], 32'h0000_1234);
      check("nom_wr1", wr_log[1], 32'h0001_ABCD);
    end
    check("nom_done", {31'd0, done}, 32'd1);
    check("nom_words", {16'd0, words_written}, 32'd2);

    // restart from DONE, new load writes from base again
    wr_log.delete();
    pulse_start();
    settle(1);
    check("restart_done_clr", {31'd0, done}, 32'd0);
    send_stream('{8'h00, 8'h01, 8'h55, 8'hAA, 8'h00}, 1'b0);
    settle(2);
    check("re_nwr", 32'(wr_log.size()), 32'd1);
    if (wr_log.size() == 1) check("re_wr0", wr_log[0], 32'h0000_55AA);
    check("re_done", {31'd0, done}, 32'd1);

    // empty load
    wr_log.delete();
    pulse_start();
    send_stream('{8'h00, 8'h00, 8'h00}, 1'b0);
    settle(2);
    check("empty_nwr", 32'(wr_log.size()), 32'd0);
    check("empty_done", {31'd0, done}, 32'd1);
    check("empty_words", {16'd0, words_written}, 32'd0);

    // bad checksum
    wr_log.delete();
    pulse_start();
    send_stream('{8'h00, 8'h01, 8'hBE, 8'hEF, 8'hAF}, 1'b0);
    settle(2);
    check("bad_nwr", 32'(wr_log.size()), 32'd1);
    if (wr_log.size() == 1) check("bad_wr0", wr_log[0], 32'h0000_BEEF);
    check("bad_err", {31'd0, err}, 32'd1);
    check("bad_done", {31'd0, done}, 32'd0);
    check("bad_core_rst", {31'd0, core_rst}, 32'd1);
    check("bad_in_ready", {31'd0, in_ready}, 32'd0);

    // over-length (257 words)
    wr_log.delete();
    pulse_start();
    send_stream('{8'h01, 8'h01}, 1'b0);
    settle(1);
    check("ovl_err", {31'd0, err}, 32'd1);
    check("ovl_in_ready", {31'd0, in_ready}, 32'd0);
    settle(2);
    check("ovl_nwr", 32'(wr_log.size()), 32'd0);

    // nominal with in_valid low on alternate cycles
    wr_log.delete();
    pulse_start();
    send_stream('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0}, 1'b1);
    settle(2);
    check("bp_nwr", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() == 2) begin
      check("bp_wr0", wr_log[0], 32'h0000_1234);
      check("bp_wr1", wr_log[1], 32'h0001_ABCD);
    end
    check("bp_done", {31'd0, done}, 32'd1);

    // start mid-load is ignored
    wr_log.delete();
    pulse_start();
    send_stream('{8'h00, 8'h02, 8'h12, 8'h34}, 1'b0);
    pulse_start();
    settle(1);
    check("mid_start_words", {16'd0, words_written}, 32'd1);
    check("mid_start_ready", {31'd0, in_ready}, 32'd1);
    send_stream('{8'hAB, 8'hCD, 8'hC0}, 1'b0);
    settle(2);
    check("mid_start_nwr", 32'(wr_log.size()), 32'd2);
    check("mid_start_done", {31'd0, done}, 32'd1);

    // reset in the cycle a DATA_LO byte is accepted
    wr_log.delete();
    pulse_start();
    send_stream('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB}, 1'b0);
    @(negedge clk);
    check("pre_rst_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1; in_data = 8'hCD; rst = 1;
    @(posedge clk);
    model_reset();
    #1 rst = 0; in_valid = 0;
    settle(1);
    check("rst_wen", {31'd0, mem_wen}, 32'd0);
    check("rst_addr", {16'd0, mem_addr}, 32'h0);
    check("rst_wdata", {16'd0, mem_wdata}, 32'h0);
    check("rst_words", {16'd0, words_written}, 32'd0);
    check("rst_core", {31'd0, core_rst}, 32'd0);
    settle(2);
    check("rst_nwr", 32'(wr_log.size()), 32'd1);

    // start and rst together: rst wins
    @(negedge clk);
    start = 1; rst = 1;
    @(posedge clk);
    model_reset();
    #1 start = 0; rst = 0;
    settle(1);
    check("rst_start_ready", {31'd0, in_ready}, 32'd0);

    settle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface. The pipeline only ever reads instruction memory; this block fills it.
- Accepts a byte stream over a valid/ready handshake, assembles big-endian 16-bit instruction words and writes them to consecutive instruction-memory addresses.
- Verifies a trailing checksum over the stream.
- Holds the core in reset while a load is in progress, so the PC starts fetching only after a clean load.

Parameters:
ISIZE, 16, instruction-memory address width
DSIZE, 16, instruction word width (two bytes per word)
BASE_ADDR, 0, address of the first word written
MAX_WORDS, 256, largest accepted word count

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; begins a load in IDLE, DONE or ERROR; ignored otherwise
in_valid  input  1  in_data holds a byte
in_data  input  8  stream byte
in_ready  output  1  loader can take a byte this cycle
mem_wen  output  1  one-cycle write strobe to instruction memory
mem_addr  output  ISIZE  write address
mem_wdata  output  DSIZE  write data
core_rst  output  1  drives the core reset while loading
done  output  1  sticky, set on successful load
err  output  1  sticky, set on failed load
words_written  output  16  count of mem_wen strobes in the current load

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- All outputs are registered.
- Reset values:
  - mem_wen, in_ready, core_rst, done, err = 0
  - mem_addr = BASE_ADDR
  - mem_wdata = 0
  - words_written = 0
  - state = IDLE
- Byte acceptance: a byte is accepted in a cycle where in_valid and in_ready are both 1. in_valid=1 with in_ready=0 has no effect.
- Stream format:
  - LEN_HI, LEN_LO: 16-bit word count N, big-endian.
  - N x (DATA_HI, DATA_LO): each word is high byte first.
  - CHECK: one checksum byte.
- States:
  - IDLE: in_ready=0, core_rst=0. On start, clear done, err, words_written and the running sum, then go to LEN_HI.
  - LEN_HI: in_ready=1. On accept, latch N[15:8] and go to LEN_LO.
  - LEN_LO: in_ready=1. On accept, latch N[7:0]. Then:
    - N > MAX_WORDS: go to ERROR.
    - N = 0: go to CHECK.
    - otherwise: go to DATA_HI.
  - DATA_HI: in_ready=1. On accept, latch the high byte and go to DATA_LO.
  - DATA_LO: in_ready=1. On an accept in cycle t:
    - At t+1: mem_wen=1, mem_wdata={hi,lo}, mem_addr = BASE_ADDR + index, where index is the word index (0..N-1).
    - At t+1: words_written increments.
    - Next state is DATA_HI if fewer than N words have been assembled, otherwise CHECK.
  - CHECK: in_ready=1. On accept, compare the byte with the running sum. Equal: go to DONE. Otherwise: go to ERROR.
  - DONE: done=1, core_rst=0, in_ready=0. Stays until start (restart) or rst.
  - ERROR: err=1, core_rst=1, in_ready=0. Stays until start (restart) or rst.
- core_rst is 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK and ERROR; 0 in IDLE and DONE.
- Checksum: 8-bit sum mod 256 of every accepted byte from LEN_HI through the last DATA_LO. The checksum byte itself is excluded.
- mem_wen is high for exactly one cycle per word. Consecutive strobes are at least 2 cycles apart.
- Writes already issued before an ERROR are not undone; they stay in memory.
- start while loading (LEN_HI through CHECK) is ignored.
- start and rst in the same cycle: rst wins.
- rst mid-load: every register returns to its reset value the next cycle. No further mem_wen is issued, including a write pending from a DATA_LO accept in the same cycle.
- Address wrap: BASE_ADDR + index wraps modulo 2^ISIZE.

Test Plan:
- Nominal load:
  - Stimulus: start, then bytes 00 02 12 34 AB CD C0, in_valid held high.
  - Required: mem_wen at addr 0 with 0x1234, then at addr 1 with 0xABCD; words_written=2; done=1; err=0; core_rst falls to 0 on entering DONE.
- Empty load:
  - Stimulus: start, then 00 00 00.
  - Required: no mem_wen; done=1; words_written=0.
- Bad checksum:
  - Stimulus: start, then 00 01 BE EF AF (correct checksum is AE).
  - Required: one write of 0xBEEF to addr 0; err=1; done=0; core_rst stays 1; in_ready=0.
- Over-length, MAX_WORDS=256:
  - Stimulus: start, then 01 01.
  - Required: ERROR entered one cycle after the second byte; in_ready=0; no mem_wen.
- Backpressure and reset:
  - Stimulus: repeat the nominal stream with in_valid low on alternate cycles.
  - Required: identical writes and done=1.
  - Stimulus: assert rst the cycle a DATA_LO byte is accepted.
  - Required: no strobe follows; all outputs at reset values.
- Restart and ignored start:
  - Stimulus: pulse start in DONE.
  - Required: done clears; a new load writes from BASE_ADDR again.
  - Stimulus: pulse start mid-load.
  - Required: no effect on state or counters.
